// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_add_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble step counter; never below one bit.
    function automatic int cnt_width(input int width);
        int steps;
        steps = width / NIBBLE;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_nibble_add.sv
// Combinational 4-bit ripple-carry adder slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module nibble_add
    import serial_add_pkg::*;
(
    input  logic              ci,
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    output logic [NIBBLE-1:0] s,
    output logic              co
);

    logic [NIBBLE:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[NIBBLE];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial multi-precision adder: one shared 4-bit slice, LSB nibble first; SUB_EN adds a sub port.
// Latency: WIDTH/4+1 edges from accepted start to the one-cycle done pulse.
// Backpressure: start is ignored while busy; no queuing, result held until the next done.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]          a_sh_q, a_sh_d;
    logic [WIDTH-1:0]          b_sh_q, b_sh_d;
    logic [WIDTH-NIBBLE-1:0]   sum_sh_q, sum_sh_d;
    logic                      cy_q, cy_d;
    logic [WIDTH-1:0]          sum_q, sum_d;
    logic                      co_q, co_d;
    logic                      ovf_q, ovf_d;

    logic [WIDTH-1:0]          b_eff;
    logic                      carry_in;
    logic [NIBBLE-1:0]         nib_s;
    logic                      nib_co;
    logic [WIDTH-1:0]          sum_wide;

`ifdef SUB_EN
    // Subtraction as a + ~b + 1; ci is deliberately ignored when sub is set.
    assign b_eff    = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : ci;
`else
    assign b_eff    = b;
    assign carry_in = ci;
`endif

    nibble_add u_nibble_add (
        .ci (cy_q),
        .a  (a_sh_q[NIBBLE-1:0]),
        .b  (b_sh_q[NIBBLE-1:0]),
        .s  (nib_s),
        .co (nib_co)
    );

    // New nibble enters at the top so the last step leaves the sum aligned.
    assign sum_wide = {nib_s, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cy_d     = cy_q;
        sum_d    = sum_q;
        co_d     = co_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b_eff;
                    cy_d     = carry_in;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {{NIBBLE{1'b0}}, a_sh_q[WIDTH-1:NIBBLE]};
                b_sh_d   = {{NIBBLE{1'b0}}, b_sh_q[WIDTH-1:NIBBLE]};
                sum_sh_d = sum_wide[WIDTH-1:NIBBLE];
                cy_d     = nib_co;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Low nibbles of the operand registers now hold the original MSB nibble.
                    sum_d   = sum_wide;
                    co_d    = nib_co;
                    ovf_d   = (a_sh_q[NIBBLE-1] == b_sh_q[NIBBLE-1]) &&
                              (nib_s[NIBBLE-1] != a_sh_q[NIBBLE-1]);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cy_q     <= 1'b0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cy_q     <= cy_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule
